// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths/divisors for the baud generator
// and a constant-foldable ceil(log2) helper for counter sizing.
package uart_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int DEF_DIV_DEF = 325;
    localparam int OSR_DEF     = 16;

    // Smallest r with 2**r >= value; usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/baud_prescaler.sv
// Baud prescaler: counts 1..div_act and emits a combinational wrap strobe
// at the period boundary. Owns the active divisor, the shadow/pending
// reload handshake and, with BAUD_FRAC_DIV_EN defined, the 4-bit
// fractional phase accumulator that stretches a period by one cycle on carry.
module baud_prescaler
    import uart_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             inp_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
`ifdef BAUD_FRAC_DIV_EN
    input  logic [3:0]       frac_in,
`endif
    output logic             wrap,
    output logic [CNT_W-1:0] div_act,
    output logic             div_ack
);

    // One extra bit so a stretched period of max divisor + 1 cannot overflow.
    localparam int EW = CNT_W + 1;

    logic [EW-1:0]    cnt;
    logic [EW-1:0]    eff_div;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] next_div;
    logic             pending;
    logic             apply;
    logic             extra;

`ifdef BAUD_FRAC_DIV_EN
    logic [3:0]       acc;
`endif

    // Effective period length, wrap detection and divisor hand-over decision.
    always_comb begin
        eff_div = (div_act == '0) ? EW'(1) : {1'b0, div_act};
        if (extra) eff_div = eff_div + EW'(1);
        // >= rather than == so a divisor shrunk while idle still wraps promptly
        wrap     = en && !sync_clr && (cnt >= eff_div);
        // A fresh strobe wins over the shadow; when idle the load is immediate.
        apply    = (div_load && (sync_clr || !en || wrap)) ||
                   (pending && (sync_clr || wrap));
        next_div = div_load ? div_in : shadow;
    end

    // Divisor shadow/pending handshake; div_ack lines up with the os_tick.
    always_ff @(posedge inp_clk or negedge rst) begin
        if (!rst) begin
            div_act <= CNT_W'(DEF_DIV);
            shadow  <= '0;
            pending <= 1'b0;
            div_ack <= 1'b0;
        end else begin
            div_ack <= apply;
            if (apply) begin
                div_act <= next_div;
                pending <= 1'b0;
            end else if (div_load) begin
                shadow  <= div_in;
                pending <= 1'b1;
            end
        end
    end

    // Prescaler counter: reload to 1 on wrap or phase clear, hold when idle.
    always_ff @(posedge inp_clk or negedge rst) begin
        if (!rst) begin
            cnt <= EW'(1);
        end else if (sync_clr || wrap) begin
            cnt <= EW'(1);
        end else if (en) begin
            cnt <= cnt + EW'(1);
        end
    end

`ifdef BAUD_FRAC_DIV_EN
    // Phase accumulator: a carry stretches the following period by one cycle.
    always_ff @(posedge inp_clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            extra <= 1'b0;
        end else if (sync_clr) begin
            acc   <= '0;
            extra <= 1'b0;
        end else if (wrap) begin
            {extra, acc} <= {1'b0, acc} + {1'b0, frac_in};
        end
    end
`else
    assign extra = 1'b0;
`endif

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator top: wraps the prescaler and adds the oversample
// counter, registered os_tick/bit_tick and the legacy baud_clk square wave.
// Optional macro BAUD_FRAC_DIV_EN adds frac_in and fractional division.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF,
    parameter int OSR     = OSR_DEF
) (
    input  logic             inp_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
`ifdef BAUD_FRAC_DIV_EN
    input  logic [3:0]       frac_in,
`endif
    output logic             div_ack,
    output logic [CNT_W-1:0] div_act,
    output logic             os_tick,
    output logic             bit_tick,
    output logic             baud_clk
);

    localparam int            OS_W    = (clog2(OSR) < 1) ? 1 : clog2(OSR);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);

    logic            wrap;
    logic [OS_W-1:0] os_cnt;

    baud_prescaler #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) u_prescaler (
        .inp_clk  (inp_clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (sync_clr),
        .div_in   (div_in),
        .div_load (div_load),
`ifdef BAUD_FRAC_DIV_EN
        .frac_in  (frac_in),
`endif
        .wrap     (wrap),
        .div_act  (div_act),
        .div_ack  (div_ack)
    );

    // Registered ticks, modulo-OSR oversample count and baud_clk toggle.
    always_ff @(posedge inp_clk or negedge rst) begin
        if (!rst) begin
            os_cnt   <= '0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            baud_clk <= 1'b0;
        end else begin
            // wrap is already suppressed during sync_clr and while en=0
            os_tick  <= wrap;
            bit_tick <= wrap && (os_cnt == OS_LAST);
            if (sync_clr) begin
                os_cnt   <= '0;
                baud_clk <= 1'b0;
            end else if (wrap) begin
                os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
                baud_clk <= ~baud_clk;
            end
        end
    end

endmodule
